// File: rtl/hamming_encoder_tx.sv
// hamming_encoder_tx
//
// Purpose: takes one data byte per valid/ready handshake. Each byte goes out
// as two 8-bit extended-Hamming (SECDED) codewords, low nibble first, on a
// registered valid/ready stream. An optional XOR mask can be captured with
// each byte to corrupt the selected codeword(s). This exercises the
// downstream decoder's correction and detection paths.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   in_data   in   8      data byte, [3:0] sent first
//   in_valid  in   1      in_data / inj_mask / inj_sel valid
//   in_ready  out  1      byte accepted this cycle when in_valid is also high
//   inj_mask  in   8      XOR mask for selected codewords, captured with byte
//   inj_sel   in   2      00 none, 01 low, 10 high, 11 both
//   out_data  out  8      codeword {c_all, d3, d2, d1, c2, d0, c1, c0}
//   out_valid out  1      out_data holds a codeword
//   out_ready in   1      consumer takes out_data this cycle
//   cw_count  out  CNT_W  codewords handed off since reset (wrapping)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no codeword pending, ready for a new byte
// SEND_LO | presenting low-nibble codeword, waiting for out_ready
// SEND_HI | presenting high-nibble codeword, may accept next byte on handoff

module hamming_encoder_tx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       inj_mask,
    input  logic [1:0]       inj_sel,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] byte_q;
    logic [7:0] mask_q;
    logic [1:0] sel_q;
    logic       accept;

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [6:0] cw;
        cw[0] = d[0] ^ d[1] ^ d[3];
        cw[1] = d[0] ^ d[2] ^ d[3];
        cw[2] = d[0];
        cw[3] = d[1] ^ d[2] ^ d[3];
        cw[4] = d[1];
        cw[5] = d[2];
        cw[6] = d[3];
        return {^cw, cw};
    endfunction

    // in_ready depends only on state and, in SEND_HI, out_ready; the next
    // byte may be taken in the same cycle the high codeword leaves.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                SEND_HI: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            byte_q    <= 8'h00;
            mask_q    <= 8'h00;
            sel_q     <= 2'b00;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            cw_count  <= '0;
        end else begin
            if (out_valid && out_ready)
                cw_count <= cw_count + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (accept) begin
                        byte_q    <= in_data;
                        mask_q    <= inj_mask;
                        sel_q     <= inj_sel;
                        out_data  <= encode(in_data[3:0]) ^ (inj_sel[0] ? inj_mask : 8'h00);
                        out_valid <= 1'b1;
                        state     <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (out_ready) begin
                        out_data <= encode(byte_q[7:4]) ^ (sel_q[1] ? mask_q : 8'h00);
                        state    <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (out_ready) begin
                        if (accept) begin
                            byte_q   <= in_data;
                            mask_q   <= inj_mask;
                            sel_q    <= inj_sel;
                            out_data <= encode(in_data[3:0]) ^ (inj_sel[0] ? inj_mask : 8'h00);
                            state    <= SEND_LO;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_tx.sv
module tb_hamming_encoder_tx;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] inj_mask;
    logic [1:0] inj_sel;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] cw_count;

    logic       in_ready_s;
    logic [7:0] out_data_s;
    logic       out_valid_s;
    logic [2:0] cw_count_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    hamming_encoder_tx #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .inj_mask(inj_mask), .inj_sel(inj_sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cw_count(cw_count)
    );

    hamming_encoder_tx #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s), .inj_mask(inj_mask), .inj_sel(inj_sel),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .cw_count(cw_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full single-byte transfer with out_ready held high.
    task automatic do_byte(input logic [7:0] d, input logic [7:0] m, input logic [1:0] s,
                           input logic [7:0] exp_lo, input logic [7:0] exp_hi);
        in_data   = d;
        inj_mask  = m;
        inj_sel   = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        chk("lo_valid", {7'd0, out_valid}, 8'd1);
        chk("lo_data", out_data, exp_lo);
        chk("lo_in_ready", {7'd0, in_ready}, 8'd0);
        tick();
        exp_cnt++;
        chk("hi_valid", {7'd0, out_valid}, 8'd1);
        chk("hi_data", out_data, exp_hi);
        tick();
        exp_cnt++;
        chk("done_valid", {7'd0, out_valid}, 8'd0);
        chk("done_in_ready", {7'd0, in_ready}, 8'd1);
        chk("done_count", cw_count, exp_cnt[7:0]);
    endtask

    logic [7:0] sb [4];
    logic [7:0] slo [4];
    logic [7:0] shi [4];

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; inj_mask = 8'h00;
        inj_sel = 2'b00; out_ready = 1'b0;
        sb[0] = 8'hB5; slo[0] = 8'h2D; shi[0] = 8'h55;
        sb[1] = 8'hF0; slo[1] = 8'h00; shi[1] = 8'hFF;
        sb[2] = 8'h0F; slo[2] = 8'hFF; shi[2] = 8'h00;
        sb[3] = 8'h5B; slo[3] = 8'h55; shi[3] = 8'h2D;

        tick(); tick();
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        chk("rst_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_count", cw_count, 8'h00);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {7'd0, in_ready}, 8'd1);

        do_byte(8'hB5, 8'h00, 2'b00, 8'h2D, 8'h55);
        do_byte(8'hF0, 8'h00, 2'b00, 8'h00, 8'hFF);
        do_byte(8'h0F, 8'h00, 2'b00, 8'hFF, 8'h00);
        do_byte(8'hB5, 8'h04, 2'b01, 8'h29, 8'h55);
        do_byte(8'hB5, 8'h06, 2'b11, 8'h2B, 8'h53);
        do_byte(8'hB5, 8'h06, 2'b10, 8'h2D, 8'h53);
        chk("small_count", {5'd0, cw_count_s}, {5'd0, exp_cnt[2:0]});

        // Backpressure on both codewords.
        in_data = 8'hB5; inj_mask = 8'h00; inj_sel = 2'b00;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("bp_lo_data", out_data, 8'h2D);
            chk("bp_lo_valid", {7'd0, out_valid}, 8'd1);
            chk("bp_lo_in_ready", {7'd0, in_ready}, 8'd0);
            chk("bp_lo_count", cw_count, exp_cnt[7:0]);
            tick();
        end
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_hi_data", out_data, 8'h55);
        chk("bp_hi_in_ready", {7'd0, in_ready}, 8'd1);
        chk("bp_hi_count", cw_count, exp_cnt[7:0]);
        out_ready = 1'b0;
        #1;
        chk("bp_hi_in_ready_low", {7'd0, in_ready}, 8'd0);
        tick();
        chk("bp_hi_hold_data", out_data, 8'h55);
        chk("bp_hi_hold_valid", {7'd0, out_valid}, 8'd1);
        chk("bp_hi_hold_count", cw_count, exp_cnt[7:0]);
        out_ready = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_done_valid", {7'd0, out_valid}, 8'd0);
        chk("bp_done_count", cw_count, exp_cnt[7:0]);

        // Reset while parked in SEND_HI.
        in_data = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_hi_data", out_data, 8'h00);
        chk("pre_rst_hi_valid", {7'd0, out_valid}, 8'd1);
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_count", cw_count, 8'h00);
        chk("mid_rst_in_ready", {7'd0, in_ready}, 8'd0);
        rst = 1'b0;
        exp_cnt = 0;
        do_byte(8'hB5, 8'h00, 2'b00, 8'h2D, 8'h55);

        // Streaming: four bytes back to back, out_ready held high.
        exp_cnt = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_data = sb[0]; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("st_lo_valid", {7'd0, out_valid}, 8'd1);
            chk("st_lo_data", out_data, slo[i]);
            if (i < 3) in_data = sb[i+1];
            else       in_valid = 1'b0;
            tick();
            exp_cnt++;
            chk("st_hi_valid", {7'd0, out_valid}, 8'd1);
            chk("st_hi_data", out_data, shi[i]);
            tick();
            exp_cnt++;
        end
        chk("st_end_valid", {7'd0, out_valid}, 8'd0);
        chk("st_count", cw_count, 8'd8);
        chk("st_small_count", {5'd0, cw_count_s}, 8'd0);

        // Ninth handoff wraps the 3-bit counter to 1.
        in_data = 8'hF0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_hi_data", out_data, 8'hFF);
        chk("wrap_count", cw_count, 8'd9);
        chk("wrap_small_count", {5'd0, cw_count_s}, 8'd1);
        tick();
        chk("wrap_final_count", cw_count, 8'd10);
        chk("wrap_final_small", {5'd0, cw_count_s}, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_encoder_tx.md
# hamming_encoder_tx

Upstream stage of the Hamming SECDED decoder. Accepts one data byte per valid/ready handshake, splits it into two nibbles (low first), and emits each as an 8-bit extended-Hamming codeword in the decoder's bit layout over a registered valid/ready output stream. Optional per-byte error injection lets the decoder's single- and double-error paths be exercised on silicon.

## Interface
Parameters:
- CNT_W, 8, width of the wrapping sent-codeword counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_data  in  8  data byte; [3:0] sent first, [7:4] second.
- in_valid  in  1  in_data, inj_mask and inj_sel are valid.
- in_ready  out  1  block accepts the byte this cycle.
- inj_mask  in  8  XOR mask applied to the selected codeword(s); captured with the byte.
- inj_sel  in  2  00 none, 01 low-nibble codeword, 10 high-nibble codeword, 11 both.
- out_data  out  8  codeword {c_all, d3, d2, d1, c2, d0, c1, c0}.
- out_valid  out  1  out_data holds a codeword.
- out_ready  in  1  consumer takes out_data this cycle.
- cw_count  out  CNT_W  codewords handed off since reset, wraps modulo 2^CNT_W.

## Operation
- Encoding per nibble d[3:0]: c0=d0^d1^d3, c1=d0^d2^d3, c2=d1^d2^d3. Bits: [0]=c0, [1]=c1, [2]=d0, [3]=c2, [4]=d1, [5]=d2, [6]=d3. [7]=c_all=XOR of bits [6:0], giving even overall parity.
- Injection: out_data = codeword ^ (inj_mask if the nibble is selected by inj_sel, else 0). The mask and select are registered at byte acceptance and applied unchanged to both nibbles of that byte.
- FSM states:
  - IDLE: out_valid=0, in_ready=1. Accept moves to SEND_LO.
  - SEND_LO: out_valid=1, out_data=low codeword, in_ready=0. out handshake moves to SEND_HI.
  - SEND_HI: out_valid=1, out_data=high codeword, in_ready=out_ready.
    - Out handshake with in_valid moves to SEND_LO with the new byte (back-to-back).
    - Out handshake without in_valid moves to IDLE.
    - No out handshake: stay in SEND_HI.
- Byte, mask and select are held in registers. in_data may change after acceptance.
- cw_count increments by 1 on every out_valid&&out_ready cycle and wraps at all-ones to 0.

## Timing
- Reset (rst high at an edge): state=IDLE, out_valid=0, out_data=8'h00, cw_count=0, captured byte/mask/select=0. While rst is high, in_ready=0 (combinationally forced).
- Latency: byte accepted at edge N gives the low codeword on out_data, with out_valid=1, after edge N. The high codeword follows after the edge of the low handoff.
- Outputs are registered. out_data and out_valid are stable while out_valid&&!out_ready; no codeword is dropped or duplicated under any backpressure pattern.
- in_ready is combinational from state, and from out_ready in SEND_HI only. There is no path from in_valid to in_ready.
- Throughput with out_ready held high: one codeword per cycle, one byte per 2 cycles, with no bubble between bytes.
- in_valid without in_ready: nothing captured; the upstream holds the byte.
- Simultaneous high-codeword handoff and new-byte accept in the same cycle is legal and required (back-to-back case).
- rst asserted mid-byte: the pending codeword(s) are discarded; the next cycle matches the reset state.

## Test plan
- Single byte: in_data=8'hB5, inj_sel=00, out_ready=1 -> out_data 8'h2D then 8'h55 on consecutive cycles; cw_count=2; in_ready=1 again after.
- Extremes: 8'hF0 -> 8'h00 then 8'hFF; 8'h0F -> 8'hFF then 8'h00.
- Injection: 8'hB5, inj_mask=8'h04, inj_sel=01 -> 8'h29 then 8'h55; inj_mask=8'h06, inj_sel=11 -> 8'h2B then 8'h53.
- Backpressure: out_ready low for 3 cycles while presenting 8'h2D -> out_data/out_valid held, in_ready=0; release -> 8'h55 next, and cw_count counts each handoff exactly once.
- Streaming: 4 bytes with in_valid and out_ready held high -> 8 codewords on 8 consecutive cycles; CNT_W=3 with 9 handoffs -> cw_count=1.
- Reset mid-operation: rst pulsed while in SEND_HI -> next cycle out_valid=0, out_data=0, cw_count=0; the following byte encodes correctly.
